// File: rtl/buffer_swap_arbiter_pkg.sv
// Shared types and constants for the double-buffered display arbiter.
// Holds the FSM state encoding and the counter width.
package buffer_swap_arbiter_pkg;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_RUN0 = 2'd1,
        S_RUN1 = 2'd2
    } state_t;

    localparam int CNT_W = 4;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

endpackage

// File: rtl/buffer_swap_arbiter_sync_edge_detect.sv
// Vertical-blank rising-edge detector; emits a one-cycle frame boundary strobe.
// History resets high so a marker already high at reset release is ignored.
module sync_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic sync_in,
    output logic edge_pulse
);

    logic sync_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= 1'b1;
        end else begin
            sync_q <= sync_in;
        end
    end

    assign edge_pulse = sync_in & ~sync_q;

endmodule

// File: rtl/buffer_swap_arbiter.sv
// Front/back buffer swap arbiter for a double-buffered display.
// Host writes the back buffer; frame boundaries swap it to the front.
module buffer_swap_arbiter
    import buffer_swap_arbiter_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             CSDisplay,
    input  logic             SyncVB,
    input  logic             WrReq,
    input  logic             WrDone,
    output logic             RE0,
    output logic             RE1,
    output logic             WE0,
    output logic             WE1,
    output logic             SelBuf0,
    output logic             Buf0Empty,
    output logic             Buf1Empty,
    output logic             WrGrant,
    output logic             SwapPulse,
    output logic             ResetAddr0,
    output logic             ResetAddr1,
    output logic [CNT_W-1:0] FrameCnt,
    output logic [CNT_W-1:0] DropCnt
);

    state_t state;
    logic   boundary;
    logic   back_is1;
    logic   back_empty;
    logic   done_ok;
    logic   frame_ready;

    sync_edge_detect u_sync (
        .clock      (clock),
        .reset      (reset),
        .sync_in    (SyncVB),
        .edge_pulse (boundary)
    );

    assign back_is1    = (state == S_RUN0);
    assign back_empty  = back_is1 ? Buf1Empty : Buf0Empty;
    assign WrGrant     = reset & CSDisplay & WrReq & back_empty;
    assign WE0         = WrGrant & ~back_is1;
    assign WE1         = WrGrant & back_is1;
    assign done_ok     = WrDone & back_empty;
    // A write finishing on the boundary cycle still counts as a full frame.
    assign frame_ready = ~back_empty | WrDone;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_INIT;
            Buf0Empty  <= 1'b1;
            Buf1Empty  <= 1'b1;
            SelBuf0    <= 1'b1;
            RE0        <= 1'b0;
            RE1        <= 1'b0;
            SwapPulse  <= 1'b0;
            ResetAddr0 <= 1'b0;
            ResetAddr1 <= 1'b0;
            FrameCnt   <= '0;
            DropCnt    <= '0;
        end else if (!CSDisplay) begin
            SwapPulse  <= 1'b0;
            ResetAddr0 <= 1'b0;
            ResetAddr1 <= 1'b0;
        end else begin
            SwapPulse  <= 1'b0;
            ResetAddr0 <= 1'b0;
            ResetAddr1 <= 1'b0;
            if (done_ok) begin
                if (back_is1) begin
                    Buf1Empty <= 1'b0;
                end else begin
                    Buf0Empty <= 1'b0;
                end
            end
            if (boundary) begin
                if (frame_ready) begin
                    SwapPulse <= 1'b1;
                    FrameCnt  <= FrameCnt + 1'b1;
                    unique case (state)
                        S_RUN0: begin
                            state      <= S_RUN1;
                            SelBuf0    <= 1'b0;
                            RE0        <= 1'b0;
                            RE1        <= 1'b1;
                            Buf0Empty  <= 1'b1;
                            ResetAddr1 <= 1'b1;
                        end
                        S_RUN1: begin
                            state      <= S_RUN0;
                            SelBuf0    <= 1'b1;
                            RE0        <= 1'b1;
                            RE1        <= 1'b0;
                            Buf1Empty  <= 1'b1;
                            ResetAddr0 <= 1'b1;
                        end
                        default: begin
                            state      <= S_RUN0;
                            SelBuf0    <= 1'b1;
                            RE0        <= 1'b1;
                            RE1        <= 1'b0;
                            ResetAddr0 <= 1'b1;
                        end
                    endcase
                end else begin
                    if (DropCnt != CNT_MAX) begin
                        DropCnt <= DropCnt + 1'b1;
                    end
                    ResetAddr0 <= (state == S_RUN0);
                    ResetAddr1 <= (state == S_RUN1);
                end
            end
        end
    end

endmodule

// File: tb/tb_buffer_swap_arbiter.sv
// Directed bench for buffer_swap_arbiter with hand-computed expectations.
// Inputs change 1ns after the rising edge; outputs sampled there too.
module tb_buffer_swap_arbiter;

    logic       clock;
    logic       reset;
    logic       CSDisplay;
    logic       SyncVB;
    logic       WrReq;
    logic       WrDone;
    logic       RE0;
    logic       RE1;
    logic       WE0;
    logic       WE1;
    logic       SelBuf0;
    logic       Buf0Empty;
    logic       Buf1Empty;
    logic       WrGrant;
    logic       SwapPulse;
    logic       ResetAddr0;
    logic       ResetAddr1;
    logic [3:0] FrameCnt;
    logic [3:0] DropCnt;

    int errors = 0;
    int checks = 0;
    int n_swap;
    int n_ra0;

    buffer_swap_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .CSDisplay  (CSDisplay),
        .SyncVB     (SyncVB),
        .WrReq      (WrReq),
        .WrDone     (WrDone),
        .RE0        (RE0),
        .RE1        (RE1),
        .WE0        (WE0),
        .WE1        (WE1),
        .SelBuf0    (SelBuf0),
        .Buf0Empty  (Buf0Empty),
        .Buf1Empty  (Buf1Empty),
        .WrGrant    (WrGrant),
        .SwapPulse  (SwapPulse),
        .ResetAddr0 (ResetAddr0),
        .ResetAddr1 (ResetAddr1),
        .FrameCnt   (FrameCnt),
        .DropCnt    (DropCnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".sel"}, {7'd0, SelBuf0}, 8'd1);
        check({tag, ".empty"}, {6'd0, Buf0Empty, Buf1Empty}, 8'd3);
        check({tag, ".re_we"}, {4'd0, RE0, RE1, WE0, WE1}, 8'd0);
        check({tag, ".strobes"},
              {4'd0, WrGrant, SwapPulse, ResetAddr0, ResetAddr1}, 8'd0);
        check({tag, ".cnt"}, {FrameCnt, DropCnt}, 8'h00);
    endtask

    initial begin
        reset     = 1'b0;
        CSDisplay = 1'b1;
        SyncVB    = 1'b0;
        WrReq     = 1'b0;
        WrDone    = 1'b0;
        #12;
        check_reset_vals("rst");
        step();
        reset = 1'b1;
        step();

        // first frame written to buffer 0, then displayed
        WrReq = 1'b1;
        #1;
        check("init.grant", {5'd0, WrGrant, WE0, WE1}, 8'b110);
        step();
        WrDone = 1'b1;
        step();
        WrDone = 1'b0;
        WrReq  = 1'b0;
        check("init.full", {6'd0, Buf0Empty, RE0}, 8'd0);
        SyncVB = 1'b1;
        step();
        check("run0.swap", {5'd0, SwapPulse, ResetAddr0, RE0}, 8'b111);
        check("run0.sel", {6'd0, SelBuf0, RE1}, 8'b10);
        check("run0.fcnt", {4'd0, FrameCnt}, 8'd1);
        step();
        check("run0.pulse_end", {6'd0, SwapPulse, ResetAddr0}, 8'd0);
        SyncVB = 1'b0;
        step();

        // boundaries with an empty back buffer are drops
        n_swap = 0;
        n_ra0  = 0;
        for (int i = 0; i < 3; i++) begin
            SyncVB = 1'b1;
            step();
            n_swap += int'(SwapPulse);
            n_ra0  += int'(ResetAddr0);
            SyncVB = 1'b0;
            step();
            n_swap += int'(SwapPulse);
            n_ra0  += int'(ResetAddr0);
        end
        check("drop.swaps", 8'(n_swap), 8'd0);
        check("drop.ra0", 8'(n_ra0), 8'd3);
        check("drop.cnt3", {4'd0, DropCnt}, 8'd3);
        for (int i = 0; i < 17; i++) begin
            SyncVB = 1'b1;
            step();
            SyncVB = 1'b0;
            step();
        end
        check("drop.sat", {4'd0, DropCnt}, 8'd15);
        check("drop.fcnt", {4'd0, FrameCnt}, 8'd1);

        // write buffer 1; done and boundary in the same cycle
        WrReq = 1'b1;
        #1;
        check("run0.grant", {5'd0, WrGrant, WE0, WE1}, 8'b101);
        step();
        WrDone = 1'b1;
        SyncVB = 1'b1;
        step();
        WrDone = 1'b0;
        SyncVB = 1'b0;
        check("run1.sel", {5'd0, SelBuf0, RE0, RE1}, 8'b001);
        check("run1.empty", {6'd0, Buf0Empty, Buf1Empty}, 8'b10);
        check("run1.pulse", {5'd0, SwapPulse, ResetAddr0, ResetAddr1},
              8'b101);
        check("run1.fcnt", {4'd0, FrameCnt}, 8'd2);
        #1;
        check("run1.grant", {5'd0, WrGrant, WE0, WE1}, 8'b110);
        step();
        WrDone = 1'b1;
        step();
        check("full.empty", {6'd0, Buf0Empty, Buf1Empty}, 8'b00);
        check("full.nogrant", {5'd0, WrGrant, WE0, WE1}, 8'd0);
        step();
        WrDone = 1'b0;
        check("full.ignored", {6'd0, Buf0Empty, Buf1Empty}, 8'b00);
        SyncVB = 1'b1;
        step();
        check("back0.sel", {5'd0, SelBuf0, RE0, RE1}, 8'b110);
        check("back0.empty", {6'd0, Buf0Empty, Buf1Empty}, 8'b01);
        check("back0.pulse", {5'd0, SwapPulse, ResetAddr0, ResetAddr1},
              8'b110);
        check("back0.fcnt", {4'd0, FrameCnt}, 8'd3);
        check("back0.grant", {5'd0, WrGrant, WE0, WE1}, 8'b101);
        SyncVB = 1'b0;
        step();

        // disabled across a boundary: nothing moves, no stale edge later
        CSDisplay = 1'b0;
        #1;
        check("dis.grant", {5'd0, WrGrant, WE0, WE1}, 8'd0);
        WrDone = 1'b1;
        step();
        WrDone = 1'b0;
        SyncVB = 1'b1;
        step();
        step();
        check("dis.pulse", {5'd0, SwapPulse, ResetAddr0, ResetAddr1}, 8'd0);
        check("dis.state", {5'd0, SelBuf0, Buf0Empty, Buf1Empty}, 8'b101);
        check("dis.cnt", {FrameCnt, DropCnt}, 8'h3F);
        CSDisplay = 1'b1;
        step();
        check("reen.pulse", {5'd0, SwapPulse, ResetAddr0, ResetAddr1},
              8'd0);
        check("reen.sel", {7'd0, SelBuf0}, 8'd1);

        // asynchronous reset in the middle of a write
        SyncVB = 1'b0;
        step();
        check("midw.grant", {5'd0, WrGrant, WE0, WE1}, 8'b101);
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("midrst");
        SyncVB = 1'b1;
        WrReq  = 1'b0;
        step();
        reset = 1'b1;
        step();
        step();
        check("rel.nopulse", {5'd0, SwapPulse, ResetAddr0, ResetAddr1},
              8'd0);
        check("rel.cnt", {FrameCnt, DropCnt}, 8'h00);

        // boundary in S_INIT with nothing written is a drop without rewind
        SyncVB = 1'b0;
        step();
        SyncVB = 1'b1;
        step();
        check("init.drop", {4'd0, DropCnt}, 8'd1);
        check("init.nopulse", {5'd0, SwapPulse, ResetAddr0, ResetAddr1},
              8'd0);
        check("init.re", {6'd0, RE0, RE1}, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/buffer_swap_arbiter.md
BUFFER_SWAP_ARBITER -- requirements
Module: buffer_swap_arbiter

Interface
REQ-001: Signals SHALL be: one clock; reset is asynchronous and active-low; ports named clock and reset.
REQ-002: clock  input  1  system clock; all state updates on rising edge.
REQ-003: reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-004: CSDisplay  input  1  block enable; 0 freezes all state and forces every strobe output to 0.
REQ-005: SyncVB  input  1  vertical-blank marker from display controller; a frame boundary is its rising edge.
REQ-006: WrReq  input  1  host requests write access to the back buffer.
REQ-007: WrDone  input  1  one-cycle pulse: host finished writing the back buffer.
REQ-008: RE0, RE1  output  1  read enable of buffer 0 / buffer 1, level.
REQ-009: WE0, WE1  output  1  write enable of buffer 0 / buffer 1, level.
REQ-010: SelBuf0  output  1  1 = display reads buffer 0; 0 = buffer 1.
REQ-011: Buf0Empty, Buf1Empty  output  1  1 = buffer holds no complete frame.
REQ-012: WrGrant  output  1  host write access granted this cycle.
REQ-013: SwapPulse  output  1  one-cycle pulse on each front/back exchange.
REQ-014: ResetAddr0, ResetAddr1  output  1  one-cycle pulse rewinding that buffer's read address.
REQ-015: FrameCnt  output  4  swaps performed, wraps 15->0.
REQ-016: DropCnt  output  4  boundaries with no new frame, saturates at 15.

Function
REQ-017: FSM states SHALL be S_INIT (no displayable frame), S_RUN0 (front = buffer 0), S_RUN1 (front = buffer 1).
REQ-018: Back buffer SHALL be buffer 0 in S_INIT, buffer 1 in S_RUN0, buffer 0 in S_RUN1.
REQ-019: WrGrant SHALL equal WrReq AND CSDisplay AND back buffer empty, combinationally; WE of back buffer = WrGrant, other WE = 0.
REQ-020: WrDone while back buffer empty SHALL clear that buffer's Empty flag next cycle; WrDone with back buffer full SHALL be ignored.
REQ-021: RE of front buffer SHALL be 1 in S_RUN0/S_RUN1; both RE SHALL be 0 in S_INIT; SelBuf0 = 1 in S_INIT and S_RUN0.
REQ-022: On a boundary in S_INIT with Buf0Empty = 0: go to S_RUN0, pulse ResetAddr0, SwapPulse, FrameCnt+1.
REQ-023: On a boundary in S_RUNx with back buffer full: go to other RUN state, set old front buffer Empty = 1, pulse ResetAddr of new front, SwapPulse, FrameCnt+1.
REQ-024: On a boundary with back buffer empty: stay, pulse ResetAddr of front (S_RUNx only), DropCnt+1 saturating; no SwapPulse.
REQ-025: Boundary response latency SHALL be exactly one cycle after the cycle SyncVB is first sampled high.
REQ-026: WrDone and boundary in the same cycle SHALL count the frame as complete: swap occurs.
REQ-027: SyncVB held high multiple cycles SHALL count as one boundary; SyncVB high at reset release is not a boundary.
REQ-028: While CSDisplay = 0, edge-detector history SHALL still update, so no stale boundary fires on re-enable.

Reset
REQ-029: On reset low: state S_INIT; Buf0Empty = Buf1Empty = 1; SelBuf0 = 1; RE0/RE1/WE0/WE1/WrGrant/SwapPulse/ResetAddr0/ResetAddr1 = 0; FrameCnt = DropCnt = 0; SyncVB history = 1.
REQ-030: Reset mid-frame or mid-write SHALL discard both buffers' contents status; no pulse is emitted on release.

Structure
REQ-031: Shared package SHALL hold state encoding (S_INIT = 2'd0, S_RUN0 = 2'd1, S_RUN1 = 2'd2) and counter width constant 4.
REQ-032: One sub-module sync_edge_detect SHALL register SyncVB and emit the one-cycle boundary strobe; it shares clock and reset.
REQ-033: All outputs except WrGrant and WE0/WE1 SHALL be registered.

Verification
REQ-034: Reset, WrReq=1, WrDone pulse, SyncVB edge -> WE0=1 during write; Buf0Empty=0; next cycle S_RUN0, RE0=1, SwapPulse=1, ResetAddr0=1, FrameCnt=1.
REQ-035: In S_RUN0 with Buf1Empty=1, three SyncVB edges -> no SwapPulse, ResetAddr0 three times, DropCnt=3; after 20 edges DropCnt=15.
REQ-036: In S_RUN0, WrDone and SyncVB rise same cycle -> swap to S_RUN1, SelBuf0=0, Buf0Empty=1, Buf1Empty=0.
REQ-037: Back buffer full, WrReq=1 -> WrGrant=0, WE0=WE1=0 until swap; then WrGrant=1, target toggles.
REQ-038: CSDisplay=0 across SyncVB edge, then 1 -> no state change or pulses; reset asserted mid-write -> all outputs at REQ-029 values immediately.
